morse_timebase: RTL and testbench
=================================

Name: morse_timebase

Overview:
- Parametrised successor to the fixed 50 MHz half-second/second divider.
- Generates a base tick (Morse dot unit) and a slow tick (every RATIO base ticks), each with a tick pulse and a CNT_W-bit tick counter.
- Adds a runtime speed scale (x1/x2/x4/x8 period), pause, synchronous clear, wrap/saturate mode and a wrap flag.
- Feeds the Morse decoder timing logic and the LCD refresh/blink logic.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 2: base tick rate at scale x1. BASE = CLK_HZ/TICK_HZ must be an integer ≥ 2; elaboration fails otherwise.
- RATIO, 2: base ticks per slow tick. Must be ≥ 1.
- CNT_W, 4: width of both tick counters.
- SAT, 0: 0 = counters wrap, 1 = counters saturate at 2^CNT_W-1.

Ports:
- iCLK, in, 1: system clock.
- iRST, in, 1: asynchronous active-high reset.
- iEn, in, 1: count enable. Low = pause and hold all state.
- iClr, in, 1: synchronous clear. Has priority over iEn.
- iScale, in, 2: period multiplier 2^iScale (x1, x2, x4, x8).
- oTick, out, 1: one-cycle pulse per base tick.
- oSlowTick, out, 1: one-cycle pulse per slow tick.
- oTickCnt, out, CNT_W: base tick count.
- oSlowCnt, out, CNT_W: slow tick count.
- oWrap, out, 1: one-cycle pulse on a slow-counter wrap (SAT=0) or on first reaching max (SAT=1).

Behaviour:
- Reset: the clock is iCLK; iRST is asynchronous and active-high. Reset clears to 0: prescaler pre, sub-phase ph, scale_act, oTick, oSlowTick, oTickCnt, oSlowCnt, oWrap.
- Period: P = BASE << scale_act. The prescaler is wide enough for 8*BASE-1.
- Edge priority: iClr, then iEn, then idle. All outputs are registered.
- iClr=1: pre, ph, oTickCnt and oSlowCnt go to 0; all pulses go to 0; scale_act <= iScale. No tick fires, even if pre==P-1.
- iEn=0 (no iClr): pre, ph, counters and scale_act hold; pulse outputs are 0 that cycle.
- iEn=1, pre<P-1: pre increments; pulses are 0.
- iEn=1, pre==P-1 (tick edge):
  - pre <= 0, oTick <= 1, oTickCnt advances.
  - scale_act <= iScale. A scale change therefore takes effect only from the next period, and the current period completes at the old length.
  - If ph==RATIO-1: ph <= 0, oSlowTick <= 1, oSlowCnt advances. Otherwise ph increments.
- Counter advance:
  - SAT=0: +1 modulo 2^CNT_W.
  - SAT=1: +1 only while below max, then holds. oTick and oSlowTick keep pulsing while saturated.
- oWrap:
  - SAT=0: asserted on the edge where oSlowCnt goes max -> 0.
  - SAT=1: asserted on the edge where oSlowCnt goes max-1 -> max; never again until clear or reset.
- Latency: oTick and its counter update are visible in the same cycle, P enabled cycles after reset release or clear.
- Async reset mid-period: outputs zero immediately. Counting restarts from pre=0 at x1 scale.
- iScale changes while paused are not sampled until the next tick edge or clear.

Test Plan (CLK_HZ=20, TICK_HZ=2 → BASE=10; RATIO=2; CNT_W=4):
1. Release reset, iEn=1, iScale=0 → oTick high on enabled cycles 10, 20, 30… with oTickCnt=1, 2, 3; oSlowTick on cycles 20, 40 with oSlowCnt=1, 2; pulses exactly one cycle wide.
2. SAT=0, run 32 base ticks → oTickCnt wraps 15→0 at tick 16. oSlowCnt goes 15→0 at slow tick 16 (cycle 320) with oWrap=1 for one cycle. No other oWrap.
3. SAT=1, run 40 base ticks → oTickCnt holds at 15. oSlowCnt holds at 15 from cycle 300. oWrap pulses once at cycle 300. oTick continues every 10 cycles.
4. Pause: drop iEn for 7 cycles when pre=4 → counters hold, no pulses. The next oTick arrives 7 cycles later than unpaused (cycle 17 instead of 10).
5. Scale: set iScale=2 at cycle 3 → first oTick still at cycle 10, next at cycle 50, then 90.
6. Assert iClr together with iEn at pre=9 with oTickCnt=5 → no oTick; all counters 0; next oTick 10 cycles later. Separately, pulse iRST mid-period → all outputs 0 before the next iCLK edge.

Source files
------------

// File: rtl/morse_timebase.sv
// morse_timebase: scalable Morse dot-unit tick generator with a slow tick every RATIO
// base ticks, wrap/saturating tick counters and a slow-counter wrap flag.
module morse_timebase #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2,
    parameter int RATIO   = 2,
    parameter int CNT_W   = 4,
    parameter int SAT     = 0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEn,
    input  logic             iClr,
    input  logic [1:0]       iScale,
    output logic             oTick,
    output logic             oSlowTick,
    output logic [CNT_W-1:0] oTickCnt,
    output logic [CNT_W-1:0] oSlowCnt,
    output logic             oWrap
);
    localparam int BASE = CLK_HZ / TICK_HZ;
    localparam int PW   = $clog2(8 * BASE);
    localparam int PHW  = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] MAX = '1;

    generate
        if (BASE < 2 || BASE * TICK_HZ != CLK_HZ || RATIO < 1) begin : g_bad_param
            $error("morse_timebase: CLK_HZ/TICK_HZ must be an integer >= 2 and RATIO >= 1");
        end
    endgenerate

    logic [PW-1:0]  pre;
    logic [PHW-1:0] ph;
    logic [1:0]     scale_act;
    logic [PW-1:0]  last;
    logic           tick;
    logic           slow;
    logic           wrap_hit;

    // Period length follows the scale latched at the previous tick edge, not the live input.
    assign last     = (PW'(BASE) << scale_act) - PW'(1);
    assign tick     = iEn && pre == last;
    assign slow     = tick && ph == PHW'(RATIO - 1);
    assign wrap_hit = SAT != 0 ? oSlowCnt == MAX - CNT_W'(1) : oSlowCnt == MAX;

    function automatic logic [CNT_W-1:0] adv(input logic [CNT_W-1:0] c);
        return (SAT != 0 && c == MAX) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pre       <= '0;
            ph        <= '0;
            scale_act <= '0;
            oTick     <= 1'b0;
            oSlowTick <= 1'b0;
            oTickCnt  <= '0;
            oSlowCnt  <= '0;
            oWrap     <= 1'b0;
        end else if (iClr) begin
            pre       <= '0;
            ph        <= '0;
            scale_act <= iScale;
            oTick     <= 1'b0;
            oSlowTick <= 1'b0;
            oTickCnt  <= '0;
            oSlowCnt  <= '0;
            oWrap     <= 1'b0;
        end else begin
            oTick     <= tick;
            oSlowTick <= slow;
            oWrap     <= slow && wrap_hit;
            if (iEn)
                pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                scale_act <= iScale;
                oTickCnt  <= adv(oTickCnt);
                ph        <= slow ? '0 : ph + PHW'(1);
            end
            if (slow)
                oSlowCnt <= adv(oSlowCnt);
        end
    end
endmodule

// File: tb/tb_morse_timebase.sv
// tb_morse_timebase: wrapping and saturating instances driven in parallel, checked every
// cycle against a tick-total model plus directed hand-computed expectations.
module tb_morse_timebase;
    localparam int BASE  = 10;
    localparam int RATIO = 2;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iEn = 1'b1;
    logic       iClr = 1'b0;
    logic [1:0] iScale = 2'd0;

    logic       t0, st0, w0, t1, st1, w1;
    logic [3:0] tc0, sc0, tc1, sc1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 iCLK = ~iCLK;

    morse_timebase #(.CLK_HZ(20), .TICK_HZ(2), .RATIO(RATIO), .CNT_W(4), .SAT(0)) u_wrap (
        .iCLK(iCLK), .iRST(iRST), .iEn(iEn), .iClr(iClr), .iScale(iScale),
        .oTick(t0), .oSlowTick(st0), .oTickCnt(tc0), .oSlowCnt(sc0), .oWrap(w0));

    morse_timebase #(.CLK_HZ(20), .TICK_HZ(2), .RATIO(RATIO), .CNT_W(4), .SAT(1)) u_sat (
        .iCLK(iCLK), .iRST(iRST), .iEn(iEn), .iClr(iClr), .iScale(iScale),
        .oTick(t1), .oSlowTick(st1), .oTickCnt(tc1), .oSlowCnt(sc1), .oWrap(w1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts enabled cycles in the current period and total base ticks since clear.
    int m_cyc = 0, m_scl = 0, m_n = 0, m_s = 0;
    bit m_tick = 0, m_slow = 0, m_wrap0 = 0, m_wrap1 = 0;

    always @(posedge iCLK or posedge iRST) begin
        m_tick = 0; m_slow = 0; m_wrap0 = 0; m_wrap1 = 0;
        if (iRST) begin
            m_cyc = 0; m_scl = 0; m_n = 0;
        end else if (iClr) begin
            m_cyc = 0; m_n = 0; m_scl = iScale;
        end else if (iEn) begin
            m_cyc++;
            if (m_cyc == (BASE << m_scl)) begin
                m_cyc = 0;
                m_n++;
                m_tick = 1;
                m_scl = iScale;
                if (m_n % RATIO == 0) begin
                    m_s = m_n / RATIO;
                    m_slow = 1;
                    m_wrap0 = (m_s % 16 == 0);
                    m_wrap1 = (m_s == 15);
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (!iRST) begin
            chk("tick_w", t0, m_tick);
            chk("slow_w", st0, m_slow);
            chk("tcnt_w", tc0, m_n % 16);
            chk("scnt_w", sc0, (m_n / RATIO) % 16);
            chk("wrap_w", w0, m_wrap0);
            chk("tick_s", t1, m_tick);
            chk("slow_s", st1, m_slow);
            chk("tcnt_s", tc1, m_n > 15 ? 15 : m_n);
            chk("scnt_s", sc1, (m_n / RATIO) > 15 ? 15 : m_n / RATIO);
            chk("wrap_s", w1, m_wrap1);
        end
    end

    task automatic step(input int k = 1);
        repeat (k) begin
            @(negedge iCLK);
            #1;
        end
    endtask

    task automatic clear();
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        chk("clr_tick", t0, 0);
        chk("clr_tcnt", tc0, 0);
    endtask

    int nw0 = 0, nw1 = 0, nt1 = 0;

    initial begin
        step(2);
        chk("rst_tcnt", tc0, 0);
        chk("rst_scnt", sc1, 0);
        iRST = 1'b0;
        // Free run from reset: first ticks, wrap vs saturate.
        for (int c = 1; c <= 400; c++) begin
            step();
            nw0 += w0;
            nw1 += w1;
            nt1 += t1;
            if (c == 9)  chk("t1_pre_tick", t0, 0);
            if (c == 10) begin chk("t1_tick10", t0, 1); chk("t1_cnt10", tc0, 1); end
            if (c == 11) chk("t1_width", t0, 0);
            if (c == 20) begin chk("t1_slow20", st0, 1); chk("t1_scnt20", sc0, 1); chk("t1_cnt20", tc0, 2); end
            if (c == 160) begin chk("t2_tc_wrap", tc0, 0); chk("t3_tc_hold", tc1, 15); end
            if (c == 300) begin chk("t3_wrap300", w1, 1); chk("t3_scnt300", sc1, 15); chk("t2_nowrap300", w0, 0); end
            if (c == 320) begin chk("t2_wrap320", w0, 1); chk("t2_scnt320", sc0, 0); chk("t3_scnt320", sc1, 15); end
        end
        chk("t2_wrap_count", nw0, 1);
        chk("t3_wrap_count", nw1, 1);
        chk("t3_tick_count", nt1, 40);
        // Pause for 7 cycles at pre=4.
        clear();
        step(4);
        iEn = 1'b0;
        step(7);
        chk("t4_hold_tcnt", tc0, 0);
        iEn = 1'b1;
        step(5);
        chk("t4_no_tick16", t0, 0);
        step();
        chk("t4_tick17", t0, 1);
        chk("t4_cnt17", tc0, 1);
        // Scale x4 requested mid-period.
        clear();
        step(3);
        iScale = 2'd2;
        step(7);
        chk("t5_tick10", t0, 1);
        step(20);
        chk("t5_no_tick30", t0, 0);
        step(20);
        chk("t5_tick50", t0, 1);
        chk("t5_cnt50", tc0, 2);
        step(40);
        chk("t5_tick90", t0, 1);
        chk("t5_cnt90", tc0, 3);
        iScale = 2'd0;
        // Clear at pre=9 beats the pending tick.
        clear();
        step(59);
        chk("t6_cnt59", tc0, 5);
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        chk("t6_clr_tick", t0, 0);
        chk("t6_clr_tcnt", tc0, 0);
        chk("t6_clr_scnt", sc0, 0);
        step(9);
        chk("t6_no_tick9", t0, 0);
        step();
        chk("t6_tick10", t0, 1);
        chk("t6_cnt10", tc0, 1);
        // Asynchronous reset mid-period with a pending x8 scale request.
        step(3);
        chk("t6_pre_rst_cnt", tc0, 1);
        iScale = 2'd3;
        iRST = 1'b1;
        #1;
        chk("t6_rst_tcnt", tc0, 0);
        chk("t6_rst_scnt", sc0, 0);
        chk("t6_rst_tcnt_s", tc1, 0);
        chk("t6_rst_tick", t0 | st0 | w0, 0);
        step(2);
        iRST = 1'b0;
        step(10);
        chk("t6_x1_tick10", t0, 1);
        step(80);
        chk("t6_x8_tick90", t0, 1);
        chk("t6_x8_cnt90", tc0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
